groestl_round_ctrl: RTL
=======================

// Module: groestl_round_ctrl
// PURPOSE
//  Iterative round sequencer for the Groestl-1024 P permutation datapath (round-indexed S-box/shift stage
//  + mix_bytes, fixed register latency). Accepts a 1024-bit state, drives the shared datapath ROUNDS
//  times with round index 0..ROUNDS-1, feeds each result back, returns the final state.
//  Sits between the hash-core message scheduler and one permutation_p instance.
// PARAMETERS
//  ROUNDS        14  rounds per permutation; legal 1..16 (round port is 4 bits)
//  PERM_LATENCY  2   clock edges from perm_in/perm_round stable to perm_out valid; legal >=1
// PORTS
//  clk         in   1     single clock, all logic on rising edge
//  reset       in   1     asynchronous, active-high
//  in_valid    in   1     input state offered
//  in_ready    out  1     controller idle, can accept
//  in_data     in   1024  input state (byte 0 at [1023:1016])
//  out_valid   out  1     final state available
//  out_ready   in   1     consumer takes result
//  out_data    out  1024  permuted state (feed-forward applied if enabled)
//  perm_round  out  4     round index to datapath
//  perm_in     out  1024  state to datapath
//  perm_out    in   1024  datapath result, PERM_LATENCY edges after perm_in
//  busy        out  1     high in RUN or DONE
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, round_cnt=0, wait_cnt=0, state_reg=0, in_ready=1,
//    out_valid=0, busy=0, out_data=0, perm_round=0, perm_in=0. Deassert is synchronised by the user.
//  - States: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. Edge with in_valid: state_reg<=in_data, round_cnt<=0, wait_cnt<=0, -> RUN.
//  - RUN: in_ready=0; perm_in=state_reg, perm_round=round_cnt[3:0] held constant for PERM_LATENCY cycles.
//    wait_cnt increments each edge; at edge with wait_cnt==PERM_LATENCY-1: state_reg<=perm_out,
//    wait_cnt<=0; if round_cnt==ROUNDS-1 -> DONE else round_cnt<=round_cnt+1.
//  - DONE: out_valid=1, out_data=state_reg (stable while out_valid&&!out_ready). Edge with out_ready:
//    -> IDLE, out_valid<=0. No accept in the same cycle as out handshake (in_ready=0 in DONE).
//  - Latency: accept edge E0 -> out_valid high after edge E0+ROUNDS*PERM_LATENCY (28 at defaults).
//  - Throughput: one permutation per ROUNDS*PERM_LATENCY+2 cycles minimum.
//  - in_valid ignored outside IDLE; out_ready ignored outside DONE.
//  - round_cnt never exceeds ROUNDS-1; no wrap. wait_cnt width $clog2(PERM_LATENCY+1).
//  - Reset mid-RUN/DONE: immediate return to IDLE, partial state discarded, out_valid never asserted.
//  - perm_in/perm_round are registered outputs (no comb path from in_data).
// CONFIGURATION
//  GROESTL_CTRL_FEEDFWD_EN defined: in_data also latched into ff_reg at accept; out_data =
//    state_reg ^ ff_reg (Groestl output transform P(x)^x). Extra 1024 flops.
//  Undefined: out_data = state_reg; no ff_reg.
// TESTING (bench stub datapath: perm_out = perm_in + perm_round, delayed PERM_LATENCY edges)
//  1 in_data=0, defaults, out_ready=1 -> out_valid 28 cycles after accept, out_data=1024'd91.
//  2 Trace perm_round -> values 0,0,1,1,...,13,13 (each held 2 cycles), in_ready=0 throughout.
//  3 out_ready=0 for 5 cycles in DONE -> out_valid and out_data held; in_valid pulses ignored.
//  4 reset asserted at round_cnt=7 -> out_valid=0, in_ready=1 immediately; next job gives correct result.
//  5 FEEDFWD_EN, in_data=5 -> out_data=1024'd101 (96^5); without macro -> 1024'd96.
//  6 ROUNDS=10, PERM_LATENCY=3, in_data=0 -> out_valid after 30 cycles, out_data=1024'd45.

Source files
------------

// File: rtl/groestl_round_ctrl.sv
// groestl_round_ctrl: iterative round sequencer driving one Groestl-1024 P permutation datapath.
// Define GROESTL_CTRL_FEEDFWD_EN to XOR the accepted input into the result (output transform P(x)^x).
module groestl_round_ctrl #(
    parameter int ROUNDS       = 14,
    parameter int PERM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1023:0] out_data,
    output logic [3:0]    perm_round,
    output logic [1023:0] perm_in,
    input  logic [1023:0] perm_out,
    output logic          busy
);
    localparam int WW = $clog2(PERM_LATENCY + 1);
    localparam logic [WW-1:0] W_LAST = WW'(PERM_LATENCY - 1);
    localparam logic [3:0] R_LAST = 4'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e        st_q, st_d;
    logic [3:0]    round_q, round_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [1023:0] state_reg_q, state_reg_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
`ifdef GROESTL_CTRL_FEEDFWD_EN
    logic [1023:0] ff_q, ff_d;
`endif

    // next-state: accept in IDLE, hold each round for PERM_LATENCY cycles, present result in DONE
    always_comb begin
        st_d        = st_q;
        round_d     = round_q;
        wait_d      = wait_q;
        state_reg_d = state_reg_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef GROESTL_CTRL_FEEDFWD_EN
        ff_d        = ff_q;
`endif
        case (st_q)
            IDLE: if (in_valid) begin
                st_d        = RUN;
                state_reg_d = in_data;
                round_d     = 4'd0;
                wait_d      = '0;
                in_ready_d  = 1'b0;
                busy_d      = 1'b1;
`ifdef GROESTL_CTRL_FEEDFWD_EN
                ff_d        = in_data;
`endif
            end
            RUN: if (wait_q == W_LAST) begin
                wait_d      = '0;
                state_reg_d = perm_out;
                if (round_q == R_LAST) begin
                    st_d        = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end else begin
                wait_d = wait_q + 1'b1;
            end
            DONE: if (out_ready) begin
                st_d        = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
            default: st_d = IDLE;
        endcase
    end

    // state and registered outputs; async reset discards any job in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q        <= IDLE;
            round_q     <= 4'd0;
            wait_q      <= '0;
            state_reg_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GROESTL_CTRL_FEEDFWD_EN
            ff_q        <= '0;
`endif
        end else begin
            st_q        <= st_d;
            round_q     <= round_d;
            wait_q      <= wait_d;
            state_reg_q <= state_reg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef GROESTL_CTRL_FEEDFWD_EN
            ff_q        <= ff_d;
`endif
        end
    end

    // datapath drive comes straight from flops, so in_data never reaches perm_in combinationally
    assign perm_in    = state_reg_q;
    assign perm_round = round_q;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
`ifdef GROESTL_CTRL_FEEDFWD_EN
    assign out_data   = state_reg_q ^ ff_q;
`else
    assign out_data   = state_reg_q;
`endif
endmodule
